// File: rtl/cic_interp.sv
// CIC interpolator: ORDER low-rate comb stages, zero-stuffing by 2^INTERP_BITS,
// then ORDER full-rate integrators. All arithmetic wraps modulo 2^O_WIDTH.
module cic_interp #(
   parameter int I_WIDTH     = 16,
   parameter int ORDER       = 3,
   parameter int INTERP_BITS = 5,
   localparam int O_WIDTH    = I_WIDTH + (ORDER - 1) * INTERP_BITS
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic signed [I_WIDTH-1:0] i_data,
   output logic                      o_ack,
   output logic signed [O_WIDTH-1:0] o_data,
   output logic                      o_clk
);

   logic [INTERP_BITS-1:0]    r_ph;
   logic signed [O_WIDTH-1:0] r_d [ORDER];
   logic signed [O_WIDTH-1:0] r_a [ORDER];
   logic signed [O_WIDTH-1:0] r_s;
   logic signed [O_WIDTH-1:0] w_x [ORDER+1];
   logic                      w_tick;

   assign w_tick = i_en & (r_ph == '0);

   // w_x[k+1] is comb stage k's output; w_x[ORDER] feeds the zero-stuffer
   always_comb begin
      w_x[0] = O_WIDTH'(i_data);
      for (int k = 0; k < ORDER; k++) begin
         w_x[k+1] = w_x[k] - r_d[k];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ph <= '0;
         r_s  <= '0;
         for (int k = 0; k < ORDER; k++) begin
            r_d[k] <= '0;
            r_a[k] <= '0;
         end
      end else if (i_en) begin
         r_ph <= r_ph + INTERP_BITS'(1);
         r_s  <= w_tick ? w_x[ORDER] : '0;
         if (w_tick) begin
            for (int k = 0; k < ORDER; k++) begin
               r_d[k] <= w_x[k];
            end
         end
         r_a[0] <= r_a[0] + r_s;
         for (int k = 1; k < ORDER; k++) begin
            r_a[k] <= r_a[k] + r_a[k-1];
         end
      end
   end

   assign o_ack  = w_tick;
   assign o_data = r_a[ORDER-1];
   assign o_clk  = r_ph[INTERP_BITS-1];

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: two configurations checked against a convolution
// model (ORDER-fold boxcar applied to the zero-stuffed input).
module tb_cic_interp;

   localparam int RA = 4;
   localparam int RB = 32;
   localparam int NN = 3;

   typedef longint lq_t[$];

   logic              clk = 1'b0;
   logic              a_rst, a_en, a_ack, a_oclk;
   logic signed [7:0] a_data;
   logic signed [11:0] a_out;
   logic              b_rst, b_en, b_ack, b_oclk;
   logic signed [15:0] b_data;
   logic signed [25:0] b_out;

   int     total = 0;
   int     bad   = 0;
   lq_t    ha, hb, qa, qb;
   int     pha = 0;
   int     phb = 0;
   int     imp [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

   always #5 clk = ~clk;

   cic_interp #(.I_WIDTH(8), .ORDER(NN), .INTERP_BITS(2)) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .i_data(a_data),
      .o_ack(a_ack), .o_data(a_out), .o_clk(a_oclk)
   );

   cic_interp #(.I_WIDTH(16), .ORDER(NN), .INTERP_BITS(5)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_data(b_data),
      .o_ack(b_ack), .o_data(b_out), .o_clk(b_oclk)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // impulse response = ORDER-fold convolution of a length-r boxcar
   function automatic lq_t mk_h(int r, int n);
      lq_t h, t;
      h = {1};
      for (int s = 0; s < n; s++) begin
         t = {};
         for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
         for (int i = 0; i < h.size(); i++)
            for (int j = 0; j < r; j++) t[i+j] += h[i];
         h = t;
      end
      return h;
   endfunction

   // q[0] is the most recent zero-stuffed sample; output lags by n edges
   function automatic longint conv(lq_t h, lq_t q, int n);
      longint s = 0;
      for (int j = 0; j < h.size(); j++)
         if (n + j < q.size()) s += h[j] * q[n+j];
      return s;
   endfunction

   function automatic longint sx(longint v, int w);
      longint m = v << (64 - w);
      return m >>> (64 - w);
   endfunction

   task automatic cyc_a(input bit rst, input bit en, input longint d);
      a_rst = rst; a_en = en; a_data = 8'(d);
      #1;
      if (!rst) chk("a_ack", longint'(a_ack), longint'(en && pha == 0));
      @(posedge clk);
      if (rst) begin
         qa.delete(); pha = 0;
      end else if (en) begin
         qa.push_front((pha == 0) ? d : 0);
         pha = (pha + 1) % RA;
         if (qa.size() > 64) void'(qa.pop_back());
      end
      #1;
      chk("a_out", longint'(a_out), sx(conv(ha, qa, NN), 12));
      chk("a_clk", longint'(a_oclk), longint'(pha >= RA / 2));
   endtask

   task automatic cyc_b(input bit rst, input bit en, input longint d);
      b_rst = rst; b_en = en; b_data = 16'(d);
      #1;
      if (!rst) chk("b_ack", longint'(b_ack), longint'(en && phb == 0));
      @(posedge clk);
      if (rst) begin
         qb.delete(); phb = 0;
      end else if (en) begin
         qb.push_front((phb == 0) ? d : 0);
         phb = (phb + 1) % RB;
         if (qb.size() > 128) void'(qb.pop_back());
      end
      #1;
      chk("b_out", longint'(b_out), sx(conv(hb, qb, NN), 26));
      chk("b_clk", longint'(b_oclk), longint'(phb >= RB / 2));
   endtask

   initial begin
      int ec, cyc;
      bit en;
      ha = mk_h(RA, NN);
      hb = mk_h(RB, NN);
      b_rst = 1'b1; b_en = 1'b0; b_data = '0;

      // reset with full-scale input present
      cyc_a(1, 1, 127);
      cyc_a(1, 1, 127);
      chk("rst_out", longint'(a_out), 0);
      chk("rst_clk", longint'(a_oclk), 0);
      a_rst = 0; a_en = 1; #1;
      chk("rst_ack", longint'(a_ack), 1);

      // impulse straight out of reset
      for (int i = 0; i < 20; i++) begin
         cyc_a(0, 1, (i == 0) ? 1 : 0);
         chk("imp_seq", longint'(a_out), (i >= 3 && i < 13) ? imp[i-3] : 0);
      end

      // steps
      cyc_a(1, 1, 0);
      for (int i = 0; i < 30; i++) cyc_a(0, 1, 5);
      chk("step_pos", longint'(a_out), 80);
      cyc_a(1, 1, 0);
      for (int i = 0; i < 30; i++) cyc_a(0, 1, -128);
      chk("step_neg", longint'(a_out), -2048);

      // impulse with random enable gating
      cyc_a(1, 1, 0);
      ec = 0; cyc = 0;
      while (ec < 20 && cyc < 300) begin
         en = 1'($urandom_range(0, 1));
         cyc_a(0, en, (ec == 0) ? 1 : 0);
         if (en) begin
            chk("gate_seq", longint'(a_out), (ec >= 3 && ec < 13) ? imp[ec-3] : 0);
            ec++;
         end
         cyc++;
      end
      chk("gate_budget", ec, 20);

      // reset in the middle of an impulse response
      cyc_a(1, 1, 0);
      for (int i = 0; i < 6; i++) cyc_a(0, 1, (i == 0) ? 1 : 0);
      cyc_a(1, 1, 0);
      chk("mid_rst", longint'(a_out), 0);
      for (int i = 0; i < 16; i++) begin
         cyc_a(0, 1, (i == 0) ? 1 : 0);
         chk("mid_seq", longint'(a_out), (i >= 3 && i < 13) ? imp[i-3] : 0);
      end

      // random data with random gating, wrap allowed
      for (int i = 0; i < 200; i++)
         cyc_a(0, 1'($urandom_range(0, 1)), longint'($urandom_range(0, 255)) - 128);
      a_en = 0; a_rst = 0;

      // full-scale alternating input at R=32, then drain
      cyc_b(1, 1, 0);
      for (int i = 0; i < 1000 * RB; i++)
         cyc_b(0, 1, ((i / RB) % 2) ? -32767 : 32767);
      for (int i = 0; i < 200; i++) cyc_b(0, 1, 0);
      chk("wrap_drain", longint'(b_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
